// File: rtl/potential_decay_engine.sv
// Time-multiplexed LIF membrane decay engine: holds potential and decay code for
// NUM_NEURONS neurons and, on each timestep strobe, decays, writes back and streams every entry.
module potential_decay_engine #(
    parameter int          NUM_NEURONS    = 32,
    parameter int          ADDR_W         = 5,
    parameter logic [31:0] INIT_POTENTIAL = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              init_valid,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [31:0]       init_potential,
    input  logic [3:0]        init_decay_rate,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [31:0]       upd_potential,
    output logic              wr_ready,
    input  logic              decay_start,
    output logic              busy,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_potential,
    output logic              done,
    output logic              wr_dropped
);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);

    state_t            state;
    logic [31:0]       pot_mem  [NUM_NEURONS];
    logic [3:0]        rate_mem [NUM_NEURONS];
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [31:0]       rd_pot;
    logic [3:0]        rd_rate;
    logic [31:0]       decay_result;

    // Power-of-two codes only touch the exponent; 0011 is x/2 + x/4 on the significand, truncated.
    function automatic logic [31:0] apply_decay(input logic [31:0] x, input logic [3:0] code);
        logic        s;
        logic [7:0]  e;
        logic [24:0] sum;
        logic [1:0]  sh;
        logic [31:0] r;
        s   = x[31];
        e   = x[30:23];
        sum = {1'b0, 1'b1, x[22:0]} + {2'b00, 1'b1, x[22:1]};
        r   = x;
        case (code)
            4'b0010: sh = 2'd1;
            4'b0100: sh = 2'd2;
            4'b1000: sh = 2'd3;
            default: sh = 2'd0;
        endcase
        if (e == 8'hFF)
            r = x;
        else if (e == 8'h00)
            r = {s, 31'b0};
        else if (code == 4'b0011) begin
            if (sum[24])
                r = {s, e, sum[23:1]};
            else if (e == 8'd1)
                r = {s, 31'b0};
            else
                r = {s, e - 8'd1, sum[22:0]};
        end
        else if (e <= {6'b0, sh})
            r = {s, 31'b0};
        else
            r = {s, e - {6'b0, sh}, x[22:0]};
        return r;
    endfunction

    assign decay_result = apply_decay(rd_pot, rd_rate);
    assign wr_ready     = ~busy;

    // Host writes only land while idle (init overrides upd on a shared address); scan write-back
    // never overlaps them because it only happens while busy.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_mem[i]  <= INIT_POTENTIAL;
                rate_mem[i] <= 4'b0001;
            end
        end else begin
            if (!busy) begin
                if (upd_valid)
                    pot_mem[upd_addr] <= upd_potential;
                if (init_valid) begin
                    pot_mem[init_addr]  <= init_potential;
                    rate_mem[init_addr] <= init_decay_rate;
                end
            end
            if (rd_valid)
                pot_mem[rd_addr] <= decay_result;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state         <= IDLE;
            busy          <= 1'b0;
            scan_addr     <= '0;
            rd_valid      <= 1'b0;
            rd_addr       <= '0;
            rd_pot        <= '0;
            rd_rate       <= '0;
            out_valid     <= 1'b0;
            out_addr      <= '0;
            out_potential <= '0;
            done          <= 1'b0;
            wr_dropped    <= 1'b0;
        end else begin
            wr_dropped <= busy & (init_valid | upd_valid);
            rd_valid   <= (state == SCAN);
            rd_addr    <= scan_addr;
            rd_pot     <= pot_mem[scan_addr];
            rd_rate    <= rate_mem[scan_addr];
            out_valid  <= rd_valid;
            if (rd_valid) begin
                out_addr      <= rd_addr;
                out_potential <= decay_result;
            end
            done <= (state == FLUSH) && out_valid && (out_addr == LAST_ADDR);
            case (state)
                IDLE: begin
                    if (decay_start) begin
                        state     <= SCAN;
                        busy      <= 1'b1;
                        scan_addr <= '0;
                    end
                end
                SCAN: begin
                    if (scan_addr == LAST_ADDR)
                        state <= FLUSH;
                    else
                        scan_addr <= scan_addr + 1'b1;
                end
                FLUSH: begin
                    // Stay busy through the done cycle, then release.
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_potential_decay_engine.sv
// Self-checking bench for potential_decay_engine: directed scenarios plus randomized writes,
// checked against an arithmetic reference model of the neuron table.
module tb_potential_decay_engine;

    localparam int          N    = 32;
    localparam int          AW   = 5;
    localparam logic [31:0] INIT = 32'h0000_0000;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          init_valid = 1'b0;
    logic [AW-1:0] init_addr = '0;
    logic [31:0]   init_potential = '0;
    logic [3:0]    init_decay_rate = '0;
    logic          upd_valid = 1'b0;
    logic [AW-1:0] upd_addr = '0;
    logic [31:0]   upd_potential = '0;
    logic          wr_ready;
    logic          decay_start = 1'b0;
    logic          busy;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_potential;
    logic          done;
    logic          wr_dropped;

    potential_decay_engine #(.NUM_NEURONS(N), .ADDR_W(AW), .INIT_POTENTIAL(INIT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .init_valid(init_valid), .init_addr(init_addr), .init_potential(init_potential),
        .init_decay_rate(init_decay_rate),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_potential(upd_potential),
        .wr_ready(wr_ready), .decay_start(decay_start), .busy(busy),
        .out_valid(out_valid), .out_addr(out_addr), .out_potential(out_potential),
        .done(done), .wr_dropped(wr_dropped)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pot  [N];
    logic [3:0]  m_rate [N];
    logic [31:0] exp_pot [N];

    logic [31:0] got_pot   [N];
    int          got_cycle [N];
    int          done_cycle;
    int          n_results;
    int          drop_cycle;
    bit          order_bad;
    bit          busy_bad;
    logic        post_busy;

    // Decay expressed as value arithmetic: divide by 2^k via the exponent, or 3*sig/4 truncated.
    function automatic logic [31:0] ref_decay(input logic [31:0] x, input logic [3:0] code);
        int          exp_in;
        int          exp_out;
        int          divlog;
        longint      p;
        logic [22:0] frac;
        exp_in = int'(x[30:23]);
        if (exp_in == 255) return x;
        if (exp_in == 0) return {x[31], 31'b0};
        case (code)
            4'b0010: divlog = 1;
            4'b0100: divlog = 2;
            4'b1000: divlog = 3;
            default: divlog = 0;
        endcase
        if (code == 4'b0011) begin
            p = longint'({1'b1, x[22:0]}) * 3;
            if (p >= (longint'(1) << 25)) begin
                exp_out = exp_in;
                frac    = 23'(p >> 2);
            end else begin
                exp_out = exp_in - 1;
                frac    = 23'(p >> 1);
            end
        end else begin
            exp_out = exp_in - divlog;
            frac    = x[22:0];
        end
        if (exp_out <= 0) return {x[31], 31'b0};
        return {x[31], 8'(exp_out), frac};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pot[i]  = INIT;
            m_rate[i] = 4'b0001;
        end
    endtask

    task automatic write_cycle(input bit iv, input logic [AW-1:0] ia, input logic [31:0] ip,
                               input logic [3:0] ir, input bit uv, input logic [AW-1:0] ua,
                               input logic [31:0] up);
        init_valid = iv; init_addr = ia; init_potential = ip; init_decay_rate = ir;
        upd_valid = uv; upd_addr = ua; upd_potential = up;
        @(posedge CLK); #1;
        init_valid = 1'b0; upd_valid = 1'b0;
        if (uv) m_pot[ua] = up;
        if (iv) begin
            m_pot[ia]  = ip;
            m_rate[ia] = ir;
        end
    endtask

    // Runs one timestep and records what the DUT streamed; comparisons live in the callers.
    task automatic run_scan(input bit with_upd, input logic [AW-1:0] ua, input logic [31:0] uv,
                            input int inject_at);
        int cyc;
        for (int i = 0; i < N; i++) got_cycle[i] = -1;
        done_cycle = -1; n_results = 0; drop_cycle = -1; order_bad = 0; busy_bad = 0;
        if (with_upd) m_pot[ua] = uv;
        for (int i = 0; i < N; i++) exp_pot[i] = ref_decay(m_pot[i], m_rate[i]);
        for (int i = 0; i < N; i++) m_pot[i] = exp_pot[i];
        decay_start = 1'b1;
        upd_valid = with_upd; upd_addr = ua; upd_potential = uv;
        @(posedge CLK); #1;
        decay_start = 1'b0; upd_valid = 1'b0;
        cyc = 0;
        while (1) begin
            if (out_valid) begin
                if (int'(out_addr) != n_results) order_bad = 1;
                got_pot[out_addr]   = out_potential;
                got_cycle[out_addr] = cyc;
                n_results++;
            end
            if (wr_dropped && drop_cycle < 0) drop_cycle = cyc;
            if (busy !== 1'b1 || wr_ready !== 1'b0) busy_bad = 1;
            if (done) done_cycle = cyc;
            if (cyc == inject_at) begin
                upd_valid = 1'b1; upd_addr = 5'd3; upd_potential = 32'hDEAD_BEEF; decay_start = 1'b1;
            end else begin
                upd_valid = 1'b0; decay_start = 1'b0;
            end
            if (done_cycle >= 0 || cyc >= N + 10) break;
            @(posedge CLK); #1;
            cyc++;
        end
        upd_valid = 1'b0; decay_start = 1'b0;
        @(posedge CLK); #1;
        post_busy = busy;
    endtask

    task automatic test_reset();
        int bad;
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({out_valid, busy, done, wr_dropped, out_addr, out_potential} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got valid=%b busy=%b done=%b drop=%b addr=%0d pot=%h, need all 0",
                     out_valid, busy, done, wr_dropped, out_addr, out_potential);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_wr_ready: got %b need 1", wr_ready);
        end
        RST_N = 1'b1;
        model_reset();
        run_scan(0, '0, '0, -1);
        checks++;
        if (n_results != N || order_bad) begin
            failures++;
            $display("[TB] FAIL reset_scan_count: got %0d results (order_bad=%0d), need %0d in order", n_results, order_bad, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got_pot[i] !== INIT || got_cycle[i] != 2 + i) begin
                failures++;
                $display("[TB] FAIL reset_scan_entry %0d: got %h at cycle %0d, need %h at cycle %0d",
                         i, got_pot[i], got_cycle[i], INIT, 2 + i);
            end
        end
        checks++;
        if (done_cycle != N + 2) begin
            failures++;
            $display("[TB] FAIL reset_done_cycle: got %0d need %0d", done_cycle, N + 2);
        end
        checks++;
        if (busy_bad || post_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy_window: busy_bad=%0d busy_after=%b, need 0 and 0", busy_bad, post_busy);
        end
    endtask

    task automatic test_rate_codes();
        logic [31:0] want [3];
        want[0] = 32'h41A7223D; want[1] = 32'h415ED852; want[2] = 32'hBF800000;
        write_cycle(1, 5'd0, 32'h41DED852, 4'b0011, 0, '0, '0);
        write_cycle(1, 5'd1, 32'h41DED852, 4'b0010, 0, '0, '0);
        write_cycle(1, 5'd2, 32'hC1000000, 4'b1000, 0, '0, '0);
        run_scan(0, '0, '0, -1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_pot[i] !== want[i]) begin
                failures++;
                $display("[TB] FAIL rate_code addr%0d: got %h need %h", i, got_pot[i], want[i]);
            end
        end
    endtask

    task automatic test_special();
        write_cycle(1, 5'd4, 32'h01800000, 4'b1000, 0, '0, '0);
        write_cycle(1, 5'd6, 32'h80000000, 4'b1000, 0, '0, '0);
        write_cycle(1, 5'd7, 32'h7F800000, 4'b0100, 0, '0, '0);
        run_scan(0, '0, '0, -1);
        checks++;
        if (got_pot[4] !== 32'h00000000) begin
            failures++;
            $display("[TB] FAIL special_underflow: got %h need 00000000", got_pot[4]);
        end
        checks++;
        if (got_pot[6] !== 32'h80000000) begin
            failures++;
            $display("[TB] FAIL special_neg_zero: got %h need 80000000", got_pot[6]);
        end
        checks++;
        if (got_pot[7] !== 32'h7F800000) begin
            failures++;
            $display("[TB] FAIL special_inf: got %h need 7f800000", got_pot[7]);
        end
    endtask

    task automatic test_back_to_back();
        write_cycle(1, 5'd3, 32'h42000000, 4'b0010, 0, '0, '0);
        run_scan(0, '0, '0, -1);
        checks++;
        if (got_pot[3] !== 32'h41800000) begin
            failures++;
            $display("[TB] FAIL repeat_first: got %h need 41800000", got_pot[3]);
        end
        run_scan(0, '0, '0, -1);
        checks++;
        if (got_pot[3] !== 32'h41000000 || done_cycle != N + 2) begin
            failures++;
            $display("[TB] FAIL repeat_second: got %h done@%0d, need 41000000 done@%0d", got_pot[3], done_cycle, N + 2);
        end
        run_scan(1, 5'd3, 32'h40000000, -1);
        checks++;
        if (got_pot[3] !== 32'h3F800000) begin
            failures++;
            $display("[TB] FAIL start_same_cycle_upd: got %h need 3f800000", got_pot[3]);
        end
    endtask

    task automatic test_write_priority();
        write_cycle(1, 5'd5, 32'h40400000, 4'b0001, 1, 5'd5, 32'h11111111);
        write_cycle(1, 5'd8, 32'h40800000, 4'b0010, 1, 5'd9, 32'h41200000);
        run_scan(0, '0, '0, -1);
        checks++;
        if (got_pot[5] !== 32'h40400000) begin
            failures++;
            $display("[TB] FAIL init_wins: got %h need 40400000", got_pot[5]);
        end
        checks++;
        if (got_pot[8] !== 32'h40000000 || got_pot[9] !== exp_pot[9]) begin
            failures++;
            $display("[TB] FAIL dual_write: got %h/%h need 40000000/%h", got_pot[8], got_pot[9], exp_pot[9]);
        end
    endtask

    task automatic test_busy_rules();
        run_scan(0, '0, '0, 5);
        checks++;
        if (drop_cycle != 6) begin
            failures++;
            $display("[TB] FAIL wr_dropped_pulse: got cycle %0d need 6", drop_cycle);
        end
        checks++;
        if (post_busy !== 1'b0 || done_cycle != N + 2) begin
            failures++;
            $display("[TB] FAIL start_ignored_busy: busy_after=%b done@%0d, need 0 done@%0d", post_busy, done_cycle, N + 2);
        end
        run_scan(0, '0, '0, -1);
        checks++;
        if (got_pot[3] !== exp_pot[3]) begin
            failures++;
            $display("[TB] FAIL dropped_write_entry: got %h need %h", got_pot[3], exp_pot[3]);
        end
    endtask

    task automatic test_random();
        logic [3:0]  rate_tab [5];
        logic [31:0] p;
        logic [3:0]  r;
        int          sel;
        rate_tab[0] = 4'b0001; rate_tab[1] = 4'b0010; rate_tab[2] = 4'b0100;
        rate_tab[3] = 4'b1000; rate_tab[4] = 4'b0011;
        for (int round = 0; round < 3; round++) begin
            for (int w = 0; w < 12; w++) begin
                p   = $urandom;
                sel = $urandom_range(0, 4);
                if (sel == 1) p[30:23] = 8'h00;
                if (sel == 2) p[30:23] = 8'hFF;
                if (sel == 3) p[30:23] = 8'($urandom_range(1, 3));
                sel = $urandom_range(0, 5);
                r   = (sel == 5) ? 4'($urandom) : rate_tab[sel];
                write_cycle($urandom_range(0, 1) == 1, 5'($urandom), p, r,
                            $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
            end
            run_scan(0, '0, '0, -1);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (got_pot[i] !== exp_pot[i]) begin
                    failures++;
                    $display("[TB] FAIL random_r%0d addr%0d: got %h need %h", round, i, got_pot[i], exp_pot[i]);
                end
            end
        end
    endtask

    task automatic test_mid_scan_reset();
        bit found;
        bit seen_done;
        found = 0;
        decay_start = 1'b1;
        @(posedge CLK); #1;
        decay_start = 1'b0;
        for (int c = 0; c < N + 5 && !found; c++) begin
            if (out_valid && out_addr == 5'd10) found = 1;
            else begin
                @(posedge CLK); #1;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL midscan_reach: addr 10 not streamed within %0d cycles", N + 5);
        end
        RST_N = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midscan_abort: got valid=%b busy=%b need 0 0", out_valid, busy);
        end
        RST_N = 1'b1;
        model_reset();
        seen_done = 0;
        repeat (N + 5) begin
            @(posedge CLK); #1;
            if (done) seen_done = 1;
        end
        checks++;
        if (seen_done) begin
            failures++;
            $display("[TB] FAIL midscan_no_done: got done pulse, need none");
        end
        run_scan(0, '0, '0, -1);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got_pot[i] !== INIT) begin
                failures++;
                $display("[TB] FAIL midscan_entry %0d: got %h need %h", i, got_pot[i], INIT);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rate_codes();
        test_special();
        test_back_to_back();
        test_write_priority();
        test_busy_rules();
        test_random();
        test_mid_scan_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/potential_decay_engine.md
Name: potential_decay_engine

Overview:
- Clocked, time-multiplexed successor to the single-neuron decay units: one engine holds membrane potential and decay configuration for NUM_NEURONS LIF neurons.
- On each timestep strobe, it scans every neuron, applies its IEEE-754 single-precision decay, writes the result back and streams it out.
- It sits between the potential adder (which writes updated potentials) and the spike/threshold stage (which consumes the decayed stream).

Parameters:
- NUM_NEURONS, 32, number of neurons held; range 2..4096.
- ADDR_W, 5, neuron address width; must equal clog2(NUM_NEURONS).
- INIT_POTENTIAL, 32'h00000000, potential loaded into every entry at reset.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- init_valid  in  1  configuration write strobe.
- init_addr  in  ADDR_W  neuron to configure.
- init_potential  in  32  initial potential (IEEE-754).
- init_decay_rate  in  4  decay code for that neuron.
- upd_valid  in  1  adder write strobe.
- upd_addr  in  ADDR_W  neuron being updated.
- upd_potential  in  32  new potential from adder.
- wr_ready  out  1  high when init/upd writes are accepted (= ~busy).
- decay_start  in  1  timestep strobe.
- busy  out  1  scan in progress.
- out_valid  out  1  decayed result valid this cycle.
- out_addr  out  ADDR_W  neuron of out_potential.
- out_potential  out  32  decayed potential.
- done  out  1  one-cycle pulse after last result.
- wr_dropped  out  1  one-cycle pulse when a write arrived while busy.

Behaviour:
- Reset (RST_N low at a CLK edge):
  - All outputs go to 0, and the FSM goes to IDLE.
  - Every potential entry is set to INIT_POTENTIAL, and every rate to 4'b0001.
  - Reset mid-scan aborts the scan immediately; no done pulse follows.
- Storage: two NUM_NEURONS-deep arrays (32-bit potential, 4-bit rate), with registered read.
- Writes, accepted only in IDLE:
  - init_valid writes the potential and rate.
  - upd_valid writes the potential only.
  - If both target the same address in one cycle, init wins. Different addresses are both written.
  - Any write strobe while busy is discarded, and wr_dropped pulses the next cycle.
- FSM IDLE -> SCAN -> FLUSH -> IDLE:
  - In IDLE, decay_start moves to SCAN next cycle. A write in the same cycle as decay_start lands first, so the scan sees it.
  - SCAN issues reads for addr 0..NUM_NEURONS-1, one per cycle.
  - FLUSH drains the 2-stage pipe.
  - decay_start while busy is ignored.
- Pipeline:
  - Stage 1: read.
  - Stage 2: compute, register out_*, and write back to the same address.
  - out_valid for addr k is asserted 2+k cycles after the decay_start edge.
  - done pulses on the cycle after the last out_valid, i.e. NUM_NEURONS+2 cycles after start.
  - busy is high from the cycle after start through the done cycle.
- Decay arithmetic, with s = sign, e = exponent[30:23], m = mantissa:
  - 0001: divide by 1, result = x.
  - 0010: divide by 2, e-1.
  - 0100: divide by 4, e-2.
  - 1000: divide by 8, e-3.
  - 0011: multiply by 0.75 (x/2 + x/4) via a significand add, not a general FP adder:
    - sig = {1,m}; sum = sig + (sig>>1), 25 bits.
    - If sum[24] = 1: result = {s, e, sum[23:1]}.
    - Otherwise: result = {s, e-1, sum[22:0]}.
    - Rounding is truncation.
  - Any other code behaves as 0001.
- Special operands:
  - e = 255 (Inf/NaN) passes through unchanged.
  - e = 0 (zero/denormal) outputs {s, 31'b0}.
  - If the computed exponent would be <= 0, flush to {s, 31'b0}; never wrap.

Test Plan:
- Reset:
  - Hold RST_N low for 2 cycles, then issue decay_start.
  - Required: NUM_NEURONS results of 0x00000000, done at cycle 34, busy low otherwise, wr_ready=1.
- Rate codes:
  - init addr0 = 0x41DED852 with rate 0011, addr1 = 0x41DED852 with rate 0010, addr2 = 0xC1000000 with rate 1000; then start.
  - Required: addr0 -> 0x41A7223D, addr1 -> 0x415ED852, addr2 -> 0xBF800000.
- Flush and pass-through:
  - Rate 1000 on 0x01800000 -> 0x00000000.
  - Rate 1000 on 0x80000000 -> 0x80000000.
  - Rate 0100 on 0x7F800000 -> 0x7F800000 (unchanged).
- Repeat and write priority:
  - addr3 = 0x42000000 with rate 0010; start twice, back to back after done.
  - Required: 0x41800000, then 0x41000000.
  - upd_valid to addr3 with 0x40000000 in the same cycle as start -> the scan outputs 0x3F800000 at addr3.
- Busy rules:
  - upd_valid and decay_start mid-scan -> wr_dropped pulses, the entry is unchanged, and no second scan begins.
  - Simultaneous init/upd to addr5 in IDLE -> init value stored.
- Mid-scan reset:
  - Assert RST_N low at out_addr = 10.
  - Required: out_valid=0 and busy=0 next cycle, no done pulse, all entries equal INIT_POTENTIAL.
